// File: rtl/pc_sequencer_if.sv
// Control-unit to PC-sequencer bus: advance/steer inputs and PC/status outputs.
// The control side holds the master modport and the sequencer holds the slave modport.
interface pc_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             next_instruct;
  logic [1:0]       sel;
  logic             branch_taken;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  rs1;
  logic [CNT_W-1:0] no_instruct;
  logic             restart;
  logic [XLEN-1:0]  address;
  logic [XLEN-1:0]  pc_plus4;
  logic [CNT_W-1:0] retired;
  logic             eof;
  logic             trap;
  logic [XLEN-1:0]  bad_target;

  modport master (
    output next_instruct, sel, branch_taken, imm, rs1, no_instruct, restart,
    input  address, pc_plus4, retired, eof, trap, bad_target
  );

  modport slave (
    input  next_instruct, sel, branch_taken, imm, rs1, no_instruct, restart,
    output address, pc_plus4, retired, eof, trap, bad_target
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: computes the next fetch address, checks alignment,
// counts retired instructions against a limit and reports RUN/HALT/TRAP.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JALR   = 2'b10;

  state_t           r_state;
  logic [XLEN-1:0]  r_address;
  logic [CNT_W-1:0] r_retired;
  logic             r_eof;
  logic             r_trap;
  logic [XLEN-1:0]  r_bad_target;

  state_t           w_state_nxt;
  logic [XLEN-1:0]  w_address_nxt;
  logic [CNT_W-1:0] w_retired_nxt;
  logic [XLEN-1:0]  w_bad_target_nxt;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_jalr_sum;
  logic [XLEN-1:0]  w_target;
  logic             w_misaligned;
  logic [CNT_W-1:0] w_retired_inc;

  assign w_pc_plus4    = r_address + XLEN'(4);
  assign w_jalr_sum    = bus.rs1 + bus.imm;
  assign w_retired_inc = r_retired + CNT_W'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_target = r_address;
    unique case (bus.sel)
      SEL_SEQ:    w_target = w_pc_plus4;
      SEL_BRANCH: w_target = bus.branch_taken ? (r_address + bus.imm) : w_pc_plus4;
      SEL_JALR:   w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      default:    w_target = r_address;
    endcase
  end

  // Hold re-uses the current (always aligned) PC, so it can never trap.
  assign w_misaligned = (bus.sel != 2'b11) && (w_target[1:0] != 2'b00);

  always_comb begin
    w_state_nxt      = r_state;
    w_address_nxt    = r_address;
    w_retired_nxt    = r_retired;
    w_bad_target_nxt = r_bad_target;
    if (bus.restart) begin
      w_state_nxt      = ST_RUN;
      w_address_nxt    = RESET_VECTOR;
      w_retired_nxt    = '0;
      w_bad_target_nxt = '0;
    end else if (r_state == ST_RUN && bus.next_instruct) begin
      if (w_misaligned) begin
        w_state_nxt      = ST_TRAP;
        w_bad_target_nxt = w_target;
      end else begin
        w_address_nxt = w_target;
        w_retired_nxt = w_retired_inc;
        if (bus.no_instruct != '0 && w_retired_inc == bus.no_instruct) begin
          w_state_nxt = ST_HALT;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_address    <= RESET_VECTOR;
      r_retired    <= '0;
      r_eof        <= 1'b0;
      r_trap       <= 1'b0;
      r_bad_target <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_address    <= w_address_nxt;
      r_retired    <= w_retired_nxt;
      r_eof        <= (w_state_nxt == ST_HALT);
      r_trap       <= (w_state_nxt == ST_TRAP);
      r_bad_target <= w_bad_target_nxt;
    end
  end

  assign bus.address    = r_address;
  assign bus.pc_plus4   = w_pc_plus4;
  assign bus.retired    = r_retired;
  assign bus.eof        = r_eof;
  assign bus.trap       = r_trap;
  assign bus.bad_target = r_bad_target;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against an arithmetic model of the fetch-address rules.
module tb_pc_sequencer;

  logic clk;
  logic rst;

  pc_sequencer_if #(.XLEN(32), .CNT_W(16)) u_if ();
  pc_sequencer_if #(.XLEN(32), .CNT_W(4))  u_if4 ();

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h1000), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (u_if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state for the 16-bit-counter instance.
  logic [31:0] m_pc;
  int          m_ret;
  bit          m_halt;
  bit          m_trap;
  logic [31:0] m_bad;

  function automatic void model_reset();
    m_pc = 32'h0; m_ret = 0; m_halt = 0; m_trap = 0; m_bad = 32'h0;
  endfunction

  function automatic void model_step(input bit ni, input bit [1:0] s, input bit bt,
                                     input logic [31:0] im, input logic [31:0] r1,
                                     input int lim, input bit rs);
    logic [31:0] tgt;
    if (rs) begin
      model_reset();
      return;
    end
    if (m_halt || m_trap || !ni) return;
    case (s)
      2'd0:    tgt = m_pc + 32'd4;
      2'd1:    tgt = bt ? m_pc + im : m_pc + 32'd4;
      2'd2:    tgt = (r1 + im) & 32'hFFFF_FFFE;
      default: tgt = m_pc;
    endcase
    if (s != 2'd3 && (tgt % 4) != 0) begin
      m_trap = 1;
      m_bad  = tgt;
    end else begin
      m_pc  = tgt;
      m_ret = (m_ret + 1) % 65536;
      if (lim != 0 && m_ret == lim) m_halt = 1;
    end
  endfunction

  function automatic logic [113:0] model_vec();
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    return {m_pc, p4, 16'(m_ret), m_halt, m_trap, m_bad};
  endfunction

  function automatic logic [113:0] dut_vec();
    return {u_if.address, u_if.pc_plus4, u_if.retired, u_if.eof, u_if.trap, u_if.bad_target};
  endfunction

  // Drive one cycle at the falling edge and advance the model; sample 1 time unit after the rising edge.
  task automatic step(input bit ni, input bit [1:0] s, input bit bt,
                      input logic [31:0] im, input logic [31:0] r1,
                      input int lim, input bit rs);
    @(negedge clk);
    u_if.next_instruct = ni;
    u_if.sel           = s;
    u_if.branch_taken  = bt;
    u_if.imm           = im;
    u_if.rs1           = r1;
    u_if.no_instruct   = 16'(lim);
    u_if.restart       = rs;
    model_step(ni, s, bt, im, r1, lim, rs);
    @(posedge clk);
    #1;
    u_if.next_instruct = 1'b0;
    u_if.restart       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", dut_vec(), model_vec());
    end
    n_vec++;
    if ({u_if4.address, u_if4.retired, u_if4.eof, u_if4.trap} !== {32'h1000, 4'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state_cnt4: got addr %h ret %h", u_if4.address, u_if4.retired);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      step(1, 2'd0, 0, 32'h0, 32'h0, 0, 0);
      n_vec++;
      if (dut_vec() !== model_vec() || u_if.address !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL sequential_%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    n_vec++;
    if ({u_if.retired, u_if.eof, u_if.trap} !== {16'd3, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sequential_retired: got ret %0d eof %b trap %b expected 3 0 0",
               u_if.retired, u_if.eof, u_if.trap);
    end
  endtask

  task automatic test_branch();
    step(1, 2'd2, 0, 32'h0, 32'h100, 0, 0);
    step(1, 2'd1, 1, 32'hFFFF_FFF8, 32'h0, 0, 0);
    n_vec++;
    if (dut_vec() !== model_vec() || u_if.address !== 32'hF8) begin
      n_bad++;
      $display("FAIL branch_taken: got %h expected %h", dut_vec(), model_vec());
    end
    step(1, 2'd2, 0, 32'h0, 32'h100, 0, 0);
    step(1, 2'd1, 0, 32'hFFFF_FFF8, 32'h0, 0, 0);
    n_vec++;
    if (dut_vec() !== model_vec() || u_if.address !== 32'h104) begin
      n_bad++;
      $display("FAIL branch_not_taken: got %h expected %h", dut_vec(), model_vec());
    end
    step(1, 2'd3, 0, 32'h0, 32'h0, 0, 0);
    n_vec++;
    if (dut_vec() !== model_vec() || u_if.address !== 32'h104) begin
      n_bad++;
      $display("FAIL hold: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_jalr_trap();
    logic [31:0] addr_before;
    addr_before = u_if.address;
    step(1, 2'd2, 0, 32'h0, 32'h203, 0, 0);
    n_vec++;
    if (dut_vec() !== model_vec() || {u_if.trap, u_if.bad_target, u_if.address} !== {1'b1, 32'h202, addr_before}) begin
      n_bad++;
      $display("FAIL jalr_trap: got %h expected %h", dut_vec(), model_vec());
    end
    step(1, 2'd0, 0, 32'h0, 32'h0, 0, 0);
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL trap_ignores_advance: got %h expected %h", dut_vec(), model_vec());
    end
    step(0, 2'd0, 0, 32'h0, 32'h0, 0, 1);
    n_vec++;
    if (dut_vec() !== model_vec() || {u_if.address, u_if.trap, u_if.bad_target} !== {32'h0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL trap_restart: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_limit();
    for (int i = 1; i <= 4; i++) begin
      step(1, 2'd0, 0, 32'h0, 32'h0, 2, 0);
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_bad++;
        $display("FAIL limit_pulse_%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    n_vec++;
    if ({u_if.eof, u_if.address, u_if.retired} !== {1'b1, 32'h8, 16'd2}) begin
      n_bad++;
      $display("FAIL limit_halt: got eof %b addr %h ret %0d expected 1 00000008 2",
               u_if.eof, u_if.address, u_if.retired);
    end
    step(0, 2'd0, 0, 32'h0, 32'h0, 0, 1);
    n_vec++;
    if (dut_vec() !== model_vec() || u_if.eof !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_restart: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_wrap();
    step(1, 2'd2, 0, 32'h0, 32'hFFFF_FFFC, 0, 0);
    step(1, 2'd0, 0, 32'h0, 32'h0, 0, 0);
    n_vec++;
    if (dut_vec() !== model_vec() || {u_if.address, u_if.trap} !== {32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL addr_wrap: got %h expected %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      u_if4.next_instruct = 1'b1;
      @(posedge clk);
      #1;
      u_if4.next_instruct = 1'b0;
    end
    n_vec++;
    if ({u_if4.retired, u_if4.address, u_if4.eof} !== {4'd1, 32'h1044, 1'b0}) begin
      n_bad++;
      $display("FAIL retired_wrap: got ret %0d addr %h eof %b expected 1 00001044 0",
               u_if4.retired, u_if4.address, u_if4.eof);
    end
    @(negedge clk);
    u_if4.restart = 1'b1;
    @(posedge clk);
    #1;
    u_if4.restart = 1'b0;
    n_vec++;
    if ({u_if4.retired, u_if4.address} !== {4'd0, 32'h1000}) begin
      n_bad++;
      $display("FAIL restart_vector: got ret %0d addr %h expected 0 00001000",
               u_if4.retired, u_if4.address);
    end
  endtask

  task automatic test_async_reset();
    step(1, 2'd0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 2'd2, 0, 32'h1, 32'h4, 0, 0);
    @(negedge clk);
    u_if.next_instruct = 1'b1;
    u_if.sel           = 2'd0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), model_vec());
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_bad++;
      $display("FAIL async_reset_hold: got %h expected %h", dut_vec(), model_vec());
    end
    @(negedge clk);
    u_if.next_instruct = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_restart_priority();
    step(1, 2'd0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 2'd0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 2'd0, 0, 32'h0, 32'h0, 0, 1);
    n_vec++;
    if (dut_vec() !== model_vec() || {u_if.address, u_if.retired} !== {32'h0, 16'd0}) begin
      n_bad++;
      $display("FAIL restart_priority: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    int lim;
    bit ni, bt, rs;
    bit [1:0] s;
    logic [31:0] im, r1;
    for (int blk = 0; blk < 8; blk++) begin
      lim = (blk % 2 == 1) ? int'($urandom_range(1, 30)) : 0;
      for (int i = 0; i < 50; i++) begin
        ni = ($urandom_range(0, 3) != 0);
        s  = 2'($urandom_range(0, 3));
        bt = 1'($urandom);
        rs = ($urandom_range(0, 15) == 0);
        im = $urandom_range(0, 7) == 0 ? $urandom : ($urandom & 32'h0000_0FFC);
        if ($urandom_range(0, 1) == 1) im = -im;
        r1 = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
        step(ni, s, bt, im, r1, lim, rs);
        n_vec++;
        if (dut_vec() !== model_vec()) begin
          n_bad++;
          $display("FAIL random_%0d_%0d: got %h expected %h", blk, i, dut_vec(), model_vec());
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    u_if.next_instruct  = 1'b0;
    u_if.sel            = 2'd0;
    u_if.branch_taken   = 1'b0;
    u_if.imm            = '0;
    u_if.rs1            = '0;
    u_if.no_instruct    = '0;
    u_if.restart        = 1'b0;
    u_if4.next_instruct = 1'b0;
    u_if4.sel           = 2'd0;
    u_if4.branch_taken  = 1'b0;
    u_if4.imm           = '0;
    u_if4.rs1           = '0;
    u_if4.no_instruct   = '0;
    u_if4.restart       = 1'b0;

    test_reset();
    test_sequential();
    test_branch();
    test_jalr_trap();
    test_limit();
    test_wrap();
    test_async_reset();
    test_restart_priority();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
